piso_sched: RTL

//  Scheduler for the PE-array parallel-in/serial-out unloader. Accepts result vectors from the
//  PE array over valid/ready and buffers one vector. Issues load pulses to the PISO, spaced at

---
 rtl/piso_sched.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/piso_sched.sv
// rtl/piso_sched.sv - load scheduler and serial beat tracker for the PE-array PISO unloader
// One-entry hold buffer feeds PISO load pulses spaced PE_NUM apart; a delay line regenerates beat valid/index.
module piso_sched #(
    parameter int PE_NUM     = 8,
    parameter int DATA_WIDTH = 16,
    parameter int SRL_LAT    = 2,
    parameter int FCNT_W     = 16,
    localparam int EW        = 2 * DATA_WIDTH,
    localparam int VW        = PE_NUM * EW,
    localparam int IDX_W     = (PE_NUM > 1) ? $clog2(PE_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [VW-1:0]     in_data,
    output logic              piso_load,
    output logic              piso_p_in_v,
    output logic [VW-1:0]     piso_p_in,
    input  logic [EW-1:0]     piso_s_out,
    output logic              out_valid,
    output logic [EW-1:0]     out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PE_NUM - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state;
    logic [IDX_W-1:0]   cnt;
    logic [VW-1:0]      hold_q;
    logic               hold_v;
    logic [SRL_LAT-1:0] load_dly;
    logic               beat_run;
    logic [IDX_W-1:0]   beat_cnt;
    logic [FCNT_W-1:0]  frame_cnt_q;
    logic               issue;
    logic               accept;
    logic               beat_start;

    // A new frame may only load once the previous one has fully shifted out.
    assign issue    = hold_v & ((state == IDLE) | ((state == SHIFT) & (cnt == LAST_IDX)));
    assign in_ready = !hold_v | issue;
    assign accept   = in_valid & in_ready;

    assign piso_load   = issue;
    assign piso_p_in_v = issue;
    assign piso_p_in   = hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            hold_v <= 1'b0;
        end else begin
            if (accept) begin
                hold_q <= in_data;
            end
            if (accept) begin
                hold_v <= 1'b1;
            end else if (issue) begin
                hold_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state <= SHIFT;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (issue) begin
                        cnt <= '0;
                    end else if (cnt == LAST_IDX) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    generate
        if (SRL_LAT == 1) begin : g_dly1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    load_dly <= '0;
                end else begin
                    load_dly <= piso_load;
                end
            end
        end else begin : g_dlyn
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    load_dly <= '0;
                end else begin
                    load_dly <= {load_dly[SRL_LAT-2:0], piso_load};
                end
            end
        end
    endgenerate

    // The delayed pulse coincides with element 0, so beat 0 is produced combinationally.
    assign beat_start = load_dly[SRL_LAT-1];
    assign out_valid  = beat_start | beat_run;
    assign out_idx    = beat_start ? '0 : beat_cnt;
    assign out_last   = out_valid & (out_idx == LAST_IDX);
    assign out_data   = piso_s_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_run <= 1'b0;
            beat_cnt <= '0;
        end else if (beat_start) begin
            beat_run <= (LAST_IDX != '0);
            beat_cnt <= IDX_W'(1);
        end else if (beat_run) begin
            if (beat_cnt == LAST_IDX) begin
                beat_run <= 1'b0;
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (out_valid & out_last) begin
            frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign busy      = hold_v | (state == SHIFT) | (|load_dly) | out_valid;

endmodule
